// File: rtl/types_pkg.sv
// types_pkg: shared widths, scratchpad read op encodings, rFIFO request layout and scheduler states
package types_pkg;
  localparam int WORD_W = 32;
  localparam int MAT_S_W = 4;
  localparam int ROW_S_W = 4;
  localparam logic [1:0] SP_OP_LSU_RD = 2'b01;
  localparam logic [1:0] SP_OP_GEMM_RD = 2'b10;
  typedef struct packed {
    logic [1:0]         op;
    logic [WORD_W-1:0]  word;
    logic [MAT_S_W-1:0] mat;
    logic [ROW_S_W-1:0] row;
  } rfifo_req_t;
  typedef enum logic [2:0] {IDLE, ISSUE_A, ISSUE_B, ISSUE_C, WAIT_CMPL} sched_state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: GEMM/LSU round-robin arbiter, GEMM first after reset; SCHED_GEMM_PRIORITY_EN makes GEMM strict priority
module rr_arbiter2 (
  input  logic CLK,
  input  logic nRST,
  input  logic en,
  input  logic req_gemm,
  input  logic req_lsu,
  output logic gnt_gemm,
  output logic gnt_lsu
);
`ifdef SCHED_GEMM_PRIORITY_EN
  assign gnt_gemm = en && req_gemm;
  assign gnt_lsu = en && req_lsu && !req_gemm;
`else
  logic lsu_turn;
  assign gnt_gemm = en && req_gemm && !(req_lsu && lsu_turn);
  assign gnt_lsu = en && req_lsu && !(req_gemm && !lsu_turn);
  always_ff @(posedge CLK)
    if (!nRST) lsu_turn <= 1'b0;
    else if (gnt_gemm || gnt_lsu) lsu_turn <= gnt_gemm;
`endif
endmodule

// File: rtl/scratchpad_read_sched.sv
// scratchpad_read_sched: GEMM operand row sequencer merged with LSU reads into the rFIFO (SCHED_GEMM_PRIORITY_EN: GEMM priority)
module scratchpad_read_sched
  import types_pkg::*;
#(
  parameter int NUM_ROWS = 4
) (
  input  logic                               CLK,
  input  logic                               nRST,
  input  logic                               gemm_start,
  input  logic [MAT_S_W-1:0]                 gemm_matA,
  input  logic [MAT_S_W-1:0]                 gemm_matB,
  input  logic [MAT_S_W-1:0]                 gemm_matC,
  output logic                               gemm_busy,
  output logic                               gemm_done,
  output logic                               start_err,
  input  logic                               lsu_valid,
  input  logic [WORD_W-1:0]                  lsu_word,
  input  logic [MAT_S_W-1:0]                 lsu_mat,
  input  logic [ROW_S_W-1:0]                 lsu_row,
  output logic                               lsu_ready,
  input  logic                               rFIFO_full,
  input  logic                               gemm_complete,
  output logic                               rFIFO_WEN,
  output logic [WORD_W+MAT_S_W+ROW_S_W+1:0]  rFIFO_wdata
);
  sched_state_e state, state_n;
  logic [ROW_S_W-1:0] row, row_n;
  logic [MAT_S_W-1:0] mat_a, mat_b, mat_c, mat_a_n, mat_b_n, mat_c_n;
  logic issuing, last_row, gnt_gemm, gnt_lsu;
  rfifo_req_t req;
  assign issuing = state inside {ISSUE_A, ISSUE_B, ISSUE_C};
  assign last_row = row == ROW_S_W'(NUM_ROWS - 1);
  rr_arbiter2 u_arb (
    .CLK      (CLK),
    .nRST     (nRST),
    .en       (nRST && !rFIFO_full),
    .req_gemm (issuing),
    .req_lsu  (lsu_valid),
    .gnt_gemm (gnt_gemm),
    .gnt_lsu  (gnt_lsu)
  );
  always_ff @(posedge CLK)
    if (!nRST) begin
      state <= IDLE;
      row <= '0;
      mat_a <= '0;
      mat_b <= '0;
      mat_c <= '0;
    end else begin
      state <= state_n;
      row <= row_n;
      mat_a <= mat_a_n;
      mat_b <= mat_b_n;
      mat_c <= mat_c_n;
    end
  always_comb begin
    state_n = state;
    row_n = row;
    mat_a_n = mat_a;
    mat_b_n = mat_b;
    mat_c_n = mat_c;
    if (state == IDLE && gemm_start) begin
      state_n = ISSUE_A;
      row_n = '0;
      mat_a_n = gemm_matA;
      mat_b_n = gemm_matB;
      mat_c_n = gemm_matC;
    end else if (gnt_gemm) begin
      row_n = last_row ? '0 : row + ROW_S_W'(1);
      state_n = !last_row ? state : state == ISSUE_A ? ISSUE_B : state == ISSUE_B ? ISSUE_C : WAIT_CMPL;
    end else if (state == WAIT_CMPL && gemm_complete) begin
      state_n = IDLE;
    end
  end
  assign req.op = gnt_gemm ? SP_OP_GEMM_RD : SP_OP_LSU_RD;
  assign req.word = gnt_gemm ? '0 : lsu_word;
  assign req.mat = !gnt_gemm ? lsu_mat : state == ISSUE_A ? mat_a : state == ISSUE_B ? mat_b : mat_c;
  assign req.row = gnt_gemm ? row : lsu_row;
  assign rFIFO_WEN = gnt_gemm || gnt_lsu;
  assign rFIFO_wdata = rFIFO_WEN ? req : '0;
  assign lsu_ready = gnt_lsu;
  assign gemm_busy = nRST && state != IDLE;
  assign gemm_done = nRST && state == WAIT_CMPL && gemm_complete;
  assign start_err = nRST && gemm_start && state != IDLE;
endmodule
